// File: rtl/demux_e_reg.sv
// Registered one-hot demultiplexer: one valid/ready input stream steered to GN
// single-entry output slots; non-one-hot selects are consumed, flagged and counted.
module demux_e_reg #(
    parameter int GN   = 2,
    parameter int GW   = 4,
    parameter int CNTW = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [GW-1:0]    Da_In,
    input  logic             Da_In_Vld,
    output logic             Da_In_Rdy,
    input  logic [GN-1:0]    Da_En,
    output logic [GN*GW-1:0] Da_Ou,
    output logic [GN-1:0]    Da_Ou_Vld,
    input  logic [GN-1:0]    Da_Ou_Rdy,
    output logic             Err_Sel,
    input  logic             Err_Clr,
    output logic [CNTW-1:0]  Drop_Cnt
);

    logic [GN-1:0]    vld_q,  vld_d;
    logic [GN*GW-1:0] data_q, data_d;
    logic             err_q,  err_d;
    logic [CNTW-1:0]  cnt_q,  cnt_d;

    logic             sel_ok_s;
    logic [GN-1:0]    free_s;
    logic             rdy_s;
    logic             accept_s;
    logic             bad_s;

    function automatic logic is_onehot(input logic [GN-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < GN; i++) begin
            if (v[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
            end else begin
                multi = multi;
            end
        end
        return seen & ~multi;
    endfunction

    // Select decode and input handshake; a slot draining this cycle counts as free.
    always_comb begin
        sel_ok_s = is_onehot(Da_En);
        free_s   = ~vld_q | Da_Ou_Rdy;
        if (sel_ok_s) begin
            rdy_s = |(Da_En & free_s);
        end else begin
            rdy_s = 1'b1;
        end
        accept_s = Da_In_Vld & rdy_s & sel_ok_s;
        bad_s    = Da_In_Vld & ~sel_ok_s;
    end

    // Next state: fill overrides drain on the same slot, drained data is kept.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        for (int c = 0; c < GN; c++) begin
            if (accept_s && Da_En[c]) begin
                vld_d[c]           = 1'b1;
                data_d[GW*c +: GW] = Da_In;
            end else begin
                vld_d[c]           = vld_q[c] & ~Da_Ou_Rdy[c];
                data_d[GW*c +: GW] = data_q[GW*c +: GW];
            end
        end

        if (bad_s) begin
            err_d = 1'b1;
        end else if (Err_Clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        if (bad_s && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + CNTW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld_q  <= {GN{1'b0}};
            data_q <= {(GN*GW){1'b0}};
            err_q  <= 1'b0;
            cnt_q  <= {CNTW{1'b0}};
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign Da_In_Rdy = rdy_s;
    assign Da_Ou     = data_q;
    assign Da_Ou_Vld = vld_q;
    assign Err_Sel   = err_q;
    assign Drop_Cnt  = cnt_q;

endmodule

// File: tb/tb_demux_e_reg.sv
// Bench for demux_e_reg (GN=2, GW=4, CNTW=8): directed vector table, hand-written
// corner sequences and randomized traffic against a slot-level reference model.
module tb_demux_e_reg;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] Da_In;
    logic       Da_In_Vld;
    logic       Da_In_Rdy;
    logic [1:0] Da_En;
    logic [7:0] Da_Ou;
    logic [1:0] Da_Ou_Vld;
    logic [1:0] Da_Ou_Rdy;
    logic       Err_Sel;
    logic       Err_Clr;
    logic [7:0] Drop_Cnt;

    int checks   = 0;
    int failures = 0;

    // reference model: per-channel slot contents, error flag, drop count
    bit       m_vld [2];
    bit [3:0] m_dat [2];
    bit       m_err;
    int       m_cnt;

    always #5 Clk = ~Clk;

    demux_e_reg #(.GN(2), .GW(4), .CNTW(8)) dut (
        .Clk(Clk), .Rst(Rst), .Da_In(Da_In), .Da_In_Vld(Da_In_Vld),
        .Da_In_Rdy(Da_In_Rdy), .Da_En(Da_En), .Da_Ou(Da_Ou),
        .Da_Ou_Vld(Da_Ou_Vld), .Da_Ou_Rdy(Da_Ou_Rdy), .Err_Sel(Err_Sel),
        .Err_Clr(Err_Clr), .Drop_Cnt(Drop_Cnt)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_rdy(input bit [1:0] en, input bit [1:0] ordy);
        int k;
        if ($countones(en) != 1) return 1'b1;
        k = (en == 2'b01) ? 0 : 1;
        return !m_vld[k] || ordy[k];
    endfunction

    // one clock: drive inputs, check Rdy before the edge, outputs after it
    task automatic apply(input bit rst, input bit vld, input bit [3:0] din,
                         input bit [1:0] en, input bit [1:0] ordy, input bit clr);
        bit rdy;
        bit ok;
        int k;
        Rst = rst; Da_In_Vld = vld; Da_In = din; Da_En = en; Da_Ou_Rdy = ordy; Err_Clr = clr;
        @(negedge Clk);
        rdy = model_rdy(en, ordy);
        check("in_rdy", {31'd0, Da_In_Rdy}, {31'd0, rdy});
        ok = ($countones(en) == 1);
        k  = (en == 2'b10) ? 1 : 0;
        if (rst) begin
            m_vld = '{1'b0, 1'b0}; m_dat = '{4'h0, 4'h0}; m_err = 1'b0; m_cnt = 0;
        end else begin
            for (int c = 0; c < 2; c++) if (m_vld[c] && ordy[c]) m_vld[c] = 1'b0;
            if (vld && ok && rdy) begin m_vld[k] = 1'b1; m_dat[k] = din; end
            if (clr) m_err = 1'b0;
            if (vld && !ok) begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        @(posedge Clk);
        #1;
        check("ou_vld", {30'd0, Da_Ou_Vld}, {30'd0, m_vld[1], m_vld[0]});
        check("ou_dat", {24'd0, Da_Ou}, {24'd0, m_dat[1], m_dat[0]});
        check("err_sel", {31'd0, Err_Sel}, {31'd0, m_err});
        check("drop_cnt", {24'd0, Drop_Cnt}, m_cnt);
    endtask

    typedef struct {
        bit       rst, vld;
        bit [3:0] din;
        bit [1:0] en, ordy;
        bit       clr;
        bit       e_rdy;
        bit [1:0] e_vld;
        bit [7:0] e_ou;
        bit       e_err;
        bit [7:0] e_cnt;
    } vec_t;

    vec_t vt [15];

    initial begin
        // rst vld din en ordy clr | rdy vld ou err cnt (post-edge)
        vt[0]  = '{1,1,4'hF,2'b01,2'b00,0, 1,2'b00,8'h00,0,8'd0};
        vt[1]  = '{1,1,4'hF,2'b01,2'b00,0, 1,2'b00,8'h00,0,8'd0};
        vt[2]  = '{0,1,4'hA,2'b01,2'b00,0, 1,2'b01,8'h0A,0,8'd0};
        vt[3]  = '{0,1,4'h5,2'b10,2'b00,0, 1,2'b11,8'h5A,0,8'd0};
        vt[4]  = '{0,1,4'h3,2'b01,2'b00,0, 0,2'b11,8'h5A,0,8'd0};
        vt[5]  = '{0,1,4'h3,2'b01,2'b00,0, 0,2'b11,8'h5A,0,8'd0};
        vt[6]  = '{0,1,4'h3,2'b01,2'b01,0, 1,2'b11,8'h53,0,8'd0};
        vt[7]  = '{0,0,4'h0,2'b00,2'b11,0, 1,2'b00,8'h53,0,8'd0};
        vt[8]  = '{0,1,4'h9,2'b00,2'b00,0, 1,2'b00,8'h53,1,8'd1};
        vt[9]  = '{0,1,4'h9,2'b11,2'b00,0, 1,2'b00,8'h53,1,8'd2};
        vt[10] = '{0,0,4'h0,2'b00,2'b00,1, 1,2'b00,8'h53,0,8'd2};
        vt[11] = '{0,1,4'h6,2'b11,2'b00,1, 1,2'b00,8'h53,1,8'd3};
        vt[12] = '{0,0,4'h0,2'b00,2'b00,1, 1,2'b00,8'h53,0,8'd3};
        vt[13] = '{0,0,4'h0,2'b11,2'b11,0, 1,2'b00,8'h53,0,8'd3};
        vt[14] = '{1,0,4'h0,2'b00,2'b00,0, 1,2'b00,8'h00,0,8'd0};

        m_vld = '{1'b0, 1'b0}; m_dat = '{4'h0, 4'h0}; m_err = 1'b0; m_cnt = 0;
        Rst = 1'b1; Da_In_Vld = 1'b0; Da_In = 4'h0; Da_En = 2'b00; Da_Ou_Rdy = 2'b00; Err_Clr = 1'b0;
        @(posedge Clk); #1;

        for (int i = 0; i < 15; i++) begin
            Rst = vt[i].rst; Da_In_Vld = vt[i].vld; Da_In = vt[i].din;
            Da_En = vt[i].en; Da_Ou_Rdy = vt[i].ordy; Err_Clr = vt[i].clr;
            @(negedge Clk);
            check($sformatf("vec%0d_rdy", i), {31'd0, Da_In_Rdy}, {31'd0, vt[i].e_rdy});
            @(posedge Clk); #1;
            check($sformatf("vec%0d_vld", i), {30'd0, Da_Ou_Vld}, {30'd0, vt[i].e_vld});
            check($sformatf("vec%0d_ou", i), {24'd0, Da_Ou}, {24'd0, vt[i].e_ou});
            check($sformatf("vec%0d_err", i), {31'd0, Err_Sel}, {31'd0, vt[i].e_err});
            check($sformatf("vec%0d_cnt", i), {24'd0, Drop_Cnt}, {24'd0, vt[i].e_cnt});
        end
        m_vld = '{1'b0, 1'b0}; m_dat = '{4'h0, 4'h0}; m_err = 1'b0; m_cnt = 0;

        // streaming: 0x1..0xF to channel 0 back-to-back, consumer always ready
        for (int w = 1; w <= 15; w++) begin
            apply(0, 1, 4'(w), 2'b01, 2'b01, 0);
            check("stream_word", {28'd0, Da_Ou[3:0]}, w);
            check("stream_vld0", {31'd0, Da_Ou_Vld[0]}, 32'd1);
        end
        apply(0, 0, 4'h0, 2'b00, 2'b01, 0);

        // backpressure: ch1 held with 0x7 while ch0 keeps streaming
        apply(0, 1, 4'h7, 2'b10, 2'b01, 0);
        for (int i = 0; i < 10; i++) begin
            apply(0, 1, 4'(i + 2), 2'b01, 2'b01, 0);
            check("hold_ch1_dat", {28'd0, Da_Ou[7:4]}, 32'h7);
            check("hold_ch1_vld", {31'd0, Da_Ou_Vld[1]}, 32'd1);
            check("ch0_moves", {28'd0, Da_Ou[3:0]}, i + 2);
        end
        apply(0, 1, 4'h8, 2'b10, 2'b00, 0);
        check("blocked_keeps", {28'd0, Da_Ou[7:4]}, 32'h7);
        apply(0, 0, 4'h0, 2'b00, 2'b11, 0);

        // saturation of the drop counter, then reset
        for (int i = 0; i < 300; i++) apply(0, 1, 4'h1, (i % 2 == 0) ? 2'b00 : 2'b11, 2'b00, 0);
        check("sat_cnt", {24'd0, Drop_Cnt}, 32'hFF);
        apply(1, 0, 4'h0, 2'b00, 2'b00, 0);
        check("sat_rst_cnt", {24'd0, Drop_Cnt}, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            apply(($urandom_range(0, 59) == 0), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
